// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable integer clock divider.
// Each channel produces a registered divided waveform and a one-cycle
// end-of-period tick. A new divisor is first held in a per-channel shadow
// register and takes effect only at a period boundary, so no truncated
// pulse ever reaches clk_out. The sync input restarts every enabled channel
// with the same phase on the same edge.
module clk_div_multi #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 16,
  parameter int DEF_DIV  = 2,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                div_wr,
  input  logic [CH_W-1:0]     div_ch,
  input  logic [DIV_W-1:0]    div_val,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_s;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_s;
    logic [DIV_W-1:0] shadow_r;
    logic [DIV_W-1:0] shadow_s;
    logic [DIV_W-1:0] cnt_inc_s;
    logic [DIV_W-1:0] div_last_s;
    logic [DIV_W-1:0] src_s;
    logic             pend_r;
    logic             pend_s;
    logic             clk_r;
    logic             clk_s;
    logic             tick_r;
    logic             tick_s;
    logic             wr_hit_s;
    logic             boundary_s;

    // An out-of-range channel index never matches any channel, so it is ignored.
    assign wr_hit_s   = div_wr && (div_ch == CH_W'(gi));
    assign cnt_inc_s  = cnt_r + DIV_W'(1);
    assign div_last_s = div_r - DIV_W'(1);
    // A same-cycle write overrides an older shadow value (last write wins).
    assign src_s      = wr_hit_s ? div_val : shadow_r;
    // Restart point: sync, a stopped divisor (0 or 1), or the last count of the period.
    assign boundary_s = sync || (div_r < DIV_W'(2)) || (cnt_r == div_last_s);

    // Next-state for counter, divisor, shadow and outputs of this channel.
    always_comb begin
      cnt_s    = cnt_r;
      div_s    = div_r;
      shadow_s = shadow_r;
      pend_s   = pend_r;
      clk_s    = 1'b0;
      tick_s   = 1'b0;
      if (!en[gi]) begin
        // Disabled: clear the phase but keep divisor and any pending update.
        cnt_s = '0;
        if (wr_hit_s) begin
          shadow_s = div_val;
          pend_s   = 1'b1;
        end else begin
          shadow_s = shadow_r;
          pend_s   = pend_r;
        end
      end else if (boundary_s) begin
        // Period boundary: counter restarts at 0, so both outputs are low
        // whatever divisor is in force afterwards.
        cnt_s = '0;
        if (wr_hit_s || pend_r) begin
          div_s    = src_s;
          shadow_s = src_s;
          pend_s   = 1'b0;
        end else begin
          div_s    = div_r;
        end
      end else begin
        cnt_s  = cnt_inc_s;
        clk_s  = (cnt_inc_s >= (div_r >> 1));
        tick_s = (cnt_inc_s == div_last_s);
        if (wr_hit_s) begin
          shadow_s = div_val;
          pend_s   = 1'b1;
        end else begin
          shadow_s = shadow_r;
          pend_s   = pend_r;
        end
      end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r    <= '0;
        div_r    <= DIV_W'(DEF_DIV);
        shadow_r <= '0;
        pend_r   <= 1'b0;
        clk_r    <= 1'b0;
        tick_r   <= 1'b0;
      end else begin
        cnt_r    <= cnt_s;
        div_r    <= div_s;
        shadow_r <= shadow_s;
        pend_r   <= pend_s;
        clk_r    <= clk_s;
        tick_r   <= tick_s;
      end
    end

    assign clk_out[gi] = clk_r;
    assign tick[gi]    = tick_r;
    assign pending[gi] = pend_r;
  end

endmodule
